ptb2_axi4_lite_cmd_master: RTL and testbench

- AXI4-Lite master that drives the PTB2 quadratic-sequence slave at BASE_ADDR. It sits directly upstream of that slave.
- On i_start it writes coefficients A, B and C, then writes 1 to READ_EN. After a programmable wait it reads RESULT and DATA_OUT and presents them on local outputs with a done pulse.
- Replaces software polling for fabric-side self-test and autonomous use.

---
 rtl/ptb2_axi_pkg.sv | 33 +++
 rtl/ptb2_axi_timeout_cnt.sv | 30 +++
 rtl/ptb2_axi4_lite_cmd_master.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_ptb2_axi4_lite_cmd_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ptb2_axi_pkg.sv
// Shared constants for the PTB2 AXI4-Lite command master:
// register offsets of the PTB2 slave, AXI response code, FSM encoding,
// counter width and a coefficient sign-extension helper.
package ptb2_axi_pkg;

    // PTB2 slave register offsets relative to BASE_ADDR
    localparam logic [31:0] OFS_A        = 32'h0000_0000;
    localparam logic [31:0] OFS_B        = 32'h0000_0004;
    localparam logic [31:0] OFS_C        = 32'h0000_0008;
    localparam logic [31:0] OFS_READ_EN  = 32'h0000_000C;
    localparam logic [31:0] OFS_RESULT   = 32'h0000_0010;
    localparam logic [31:0] OFS_DATA_OUT = 32'h0000_0014;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_AW_W = 3'd1;
    localparam logic [2:0] ST_WR_B    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_RD_AR   = 3'd4;
    localparam logic [2:0] ST_RD_R    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    // Wait / timeout counter width (covers 1..255)
    localparam int unsigned CNT_W = 8;

    // Sign-extend a 5-bit coefficient to a 32-bit write word
    function automatic logic [31:0] sext5(input logic [4:0] v);
        return {{27{v[4]}}, v};
    endfunction

endpackage

// File: rtl/ptb2_axi_timeout_cnt.sv
// Loadable down-counter with expiry flag; used for both the post-write
// wait and the per-handshake timeout.
// Ports: i_clk, i_rst (sync, active-high), i_load/i_load_val (load has
// priority), i_en (decrement, saturating at 0), o_expired_c (count == 0).
module ptb2_axi_timeout_cnt
    import ptb2_axi_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/ptb2_axi4_lite_cmd_master.sv
// AXI4-Lite master that programs the PTB2 slave (A, B, C, READ_EN), waits
// WAIT_CYCLES, then reads RESULT and DATA_OUT and reports them with a
// one-cycle done pulse. Any handshake exceeding TIMEOUT cycles aborts.
// Ports: i_clk, i_rst (sync, active-high), i_start, i_a/i_b/i_c (signed 5b),
// o_busy, o_done, o_error (sticky), o_result[1:0], o_data[3:0],
// M_AXI_* AXI4-Lite master channels AW, W, B, AR, R.
module ptb2_axi4_lite_cmd_master
    import ptb2_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h79C0_0000,
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [4:0]  i_a,
    input  logic [4:0]  i_b,
    input  logic [4:0]  i_c,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [1:0]  o_result,
    output logic [3:0]  o_data,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT - 1);

    logic [2:0]  r_state, w_state_nxt;
    logic [4:0]  r_a, r_b, r_c, w_a_nxt, w_b_nxt, w_c_nxt;
    logic [1:0]  r_widx, w_widx_nxt;
    logic        r_ridx, w_ridx_nxt;
    logic        r_busy, w_busy_nxt, r_done, w_done_nxt, r_error, w_error_nxt;
    logic [1:0]  r_result, w_result_nxt;
    logic [3:0]  r_data, w_data_nxt;
    logic [31:0] r_awaddr, w_awaddr_nxt, r_wdata, w_wdata_nxt, r_araddr, w_araddr_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic        r_awvalid, w_awvalid_nxt, r_wvalid, w_wvalid_nxt, r_bready, w_bready_nxt;
    logic        r_arvalid, w_arvalid_nxt, r_rready, w_rready_nxt;

    logic             w_cnt_load, w_cnt_en, w_expired;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_aw_hs, w_w_hs;
    logic [1:0]       w_widx_inc;
    logic [31:0]      w_next_wdata, w_next_ofs;
    logic             w_unused_rdata;

    assign w_aw_hs    = r_awvalid && M_AXI_AWREADY;
    assign w_w_hs     = r_wvalid && M_AXI_WREADY;
    assign w_widx_inc = r_widx + 2'd1;
    assign w_unused_rdata = ^M_AXI_RDATA[31:4];

    // Payload for the write that follows the current one (index 3 is READ_EN = 1)
    always_comb begin
        w_next_wdata = sext5(r_a);
        w_next_ofs   = OFS_A;
        case (w_widx_inc)
            2'd1:    begin w_next_wdata = sext5(r_b); w_next_ofs = OFS_B;       end
            2'd2:    begin w_next_wdata = sext5(r_c); w_next_ofs = OFS_C;       end
            2'd3:    begin w_next_wdata = 32'h1;      w_next_ofs = OFS_READ_EN; end
            default: begin w_next_wdata = sext5(r_a); w_next_ofs = OFS_A;       end
        endcase
    end

    ptb2_axi_timeout_cnt u_cnt (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_cnt_load),
        .i_load_val  (w_cnt_val),
        .i_en        (w_cnt_en),
        .o_expired_c (w_expired)
    );

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_c_nxt       = r_c;
        w_widx_nxt    = r_widx;
        w_ridx_nxt    = r_ridx;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_error_nxt   = r_error;
        w_result_nxt  = r_result;
        w_data_nxt    = r_data;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_araddr_nxt  = r_araddr;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_cnt_load    = 1'b0;
        w_cnt_val     = TO_LOAD;
        w_cnt_en      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_a_nxt       = i_a;
                    w_b_nxt       = i_b;
                    w_c_nxt       = i_c;
                    w_error_nxt   = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_widx_nxt    = 2'd0;
                    w_awaddr_nxt  = BASE_ADDR + OFS_A;
                    w_wdata_nxt   = sext5(i_a);
                    w_wstrb_nxt   = 4'hF;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_cnt_load    = 1'b1;
                    w_state_nxt   = ST_WR_AW_W;
                end
            end
            ST_WR_AW_W: begin
                w_cnt_en = 1'b1;
                if (w_aw_hs) w_awvalid_nxt = 1'b0;
                if (w_w_hs)  w_wvalid_nxt  = 1'b0;
                // Both channels either handshake now or already did earlier
                if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
                    w_bready_nxt = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_state_nxt  = ST_WR_B;
                end else if (w_expired) begin
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b0;
                    w_error_nxt   = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_WR_B: begin
                w_cnt_en = 1'b1;
                if (M_AXI_BVALID) begin
                    w_bready_nxt = 1'b0;
                    if (M_AXI_BRESP != RESP_OKAY) w_error_nxt = 1'b1;
                    w_cnt_load = 1'b1;
                    if (r_widx != 2'd3) begin
                        w_widx_nxt    = w_widx_inc;
                        w_awaddr_nxt  = BASE_ADDR + w_next_ofs;
                        w_wdata_nxt   = w_next_wdata;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = ST_WR_AW_W;
                    end else begin
                        w_cnt_val   = WAIT_LOAD;
                        w_state_nxt = ST_WAIT;
                    end
                end else if (w_expired) begin
                    w_bready_nxt = 1'b0;
                    w_error_nxt  = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_WAIT: begin
                w_cnt_en = 1'b1;
                if (w_expired) begin
                    w_ridx_nxt    = 1'b0;
                    w_araddr_nxt  = BASE_ADDR + OFS_RESULT;
                    w_arvalid_nxt = 1'b1;
                    w_cnt_load    = 1'b1;
                    w_state_nxt   = ST_RD_AR;
                end
            end
            ST_RD_AR: begin
                w_cnt_en = 1'b1;
                if (M_AXI_ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_cnt_load    = 1'b1;
                    w_state_nxt   = ST_RD_R;
                end else if (w_expired) begin
                    w_arvalid_nxt = 1'b0;
                    w_error_nxt   = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_RD_R: begin
                w_cnt_en = 1'b1;
                if (M_AXI_RVALID) begin
                    w_rready_nxt = 1'b0;
                    if (M_AXI_RRESP != RESP_OKAY) w_error_nxt = 1'b1;
                    if (!r_ridx) begin
                        w_result_nxt  = M_AXI_RDATA[1:0];
                        w_ridx_nxt    = 1'b1;
                        w_araddr_nxt  = BASE_ADDR + OFS_DATA_OUT;
                        w_arvalid_nxt = 1'b1;
                        w_cnt_load    = 1'b1;
                        w_state_nxt   = ST_RD_AR;
                    end else begin
                        w_data_nxt  = M_AXI_RDATA[3:0];
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_DONE;
                    end
                end else if (w_expired) begin
                    w_rready_nxt = 1'b0;
                    w_error_nxt  = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_widx    <= '0;
            r_ridx    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_result  <= '0;
            r_data    <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_araddr  <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_c       <= w_c_nxt;
            r_widx    <= w_widx_nxt;
            r_ridx    <= w_ridx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
            r_result  <= w_result_nxt;
            r_data    <= w_data_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_araddr  <= w_araddr_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_result      = r_result;
    assign o_data        = r_data;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_ptb2_axi4_lite_cmd_master.sv
// Bench for ptb2_axi4_lite_cmd_master: a register-level AXI4-Lite slave
// model with configurable back-pressure, plus directed and random runs
// checked against the expected transaction list of each command.
module tb_ptb2_axi4_lite_cmd_master;

    localparam logic [31:0] BASE = 32'h79C0_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [4:0]  a, b, c;
    logic        busy, done, err;
    logic [1:0]  result;
    logic [3:0]  data;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    ptb2_axi4_lite_cmd_master #(.BASE_ADDR(BASE), .WAIT_CYCLES(4), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_c(c),
        .o_busy(busy), .o_done(done), .o_error(err), .o_result(result), .o_data(data),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t         wr_log[$];
    logic [31:0] rd_addr_log[$];
    logic [31:0] rd_data_log[$];
    logic [31:0] aq[$], wq[$], rq[$];
    logic [3:0]  sq[$];

    int          cfg_aw_delay = 0, cfg_w_delay = 0;
    bit          cfg_ar_never = 1'b0;
    logic [1:0]  cfg_rresp_result = 2'b00;

    int errors = 0, checks = 0;
    int done_cnt = 0, rise_mismatch = 0, aw_only_cnt = 0, ar_high_cnt = 0, b_accepts = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Coefficient as the slave should see it: signed 5-bit value as a 32-bit word
    function automatic logic [31:0] exp_coef(input logic [4:0] v);
        int s;
        s = int'(v);
        if (s > 15) s = s - 32;
        return 32'(s);
    endfunction

    // Slave model: acts at the falling edge, so every decision is stable at the next rising edge
    logic [31:0] bfm_addr;
    int          aw_cnt = 0, w_cnt = 0, b_pending = 0;
    bit          b_fire = 1'b0, r_fire = 1'b0;
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        arready = 0; rvalid = 0; rresp = 2'b00; rdata = '0;
        forever begin
            @(negedge clk);
            if (b_fire) begin bvalid = 0; b_fire = 0; b_accepts++; end
            if (!bvalid && b_pending > 0) begin bvalid = 1; bresp = 2'b00; b_pending--; end
            if (bvalid && bready) b_fire = 1;

            if (r_fire) begin rvalid = 0; r_fire = 0; end
            if (!rvalid && rq.size() > 0) begin
                bfm_addr = rq.pop_front();
                rvalid = 1;
                rdata  = $urandom;
                rresp  = (bfm_addr == BASE + 32'h10) ? cfg_rresp_result : 2'b00;
                rd_addr_log.push_back(bfm_addr);
                rd_data_log.push_back(rdata);
            end
            if (rvalid && rready) r_fire = 1;

            if (awvalid) begin
                if (aw_cnt >= cfg_aw_delay) awready = 1; else begin awready = 0; aw_cnt++; end
            end else begin awready = 0; aw_cnt = 0; end
            if (awvalid && awready) begin aq.push_back(awaddr); aw_cnt = 0; end

            if (wvalid) begin
                if (w_cnt >= cfg_w_delay) wready = 1; else begin wready = 0; w_cnt++; end
            end else begin wready = 0; w_cnt = 0; end
            if (wvalid && wready) begin wq.push_back(wdata); sq.push_back(wstrb); w_cnt = 0; end

            while (aq.size() > 0 && wq.size() > 0) begin
                wr_log.push_back({aq.pop_front(), wq.pop_front(), sq.pop_front()});
                b_pending++;
            end

            arready = arvalid && !cfg_ar_never;
            if (arvalid && arready) rq.push_back(araddr);
        end
    end

    // Protocol monitor
    logic prev_aw = 1'b0, prev_w = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if ((awvalid && !prev_aw) != (wvalid && !prev_w)) rise_mismatch++;
            if (awvalid && !wvalid) aw_only_cnt++;
            if (arvalid) ar_high_cnt++;
            prev_aw = awvalid;
            prev_w  = wvalid;
        end
    end

    // One command: start, optional second start while busy, then check the whole exchange
    task automatic do_run(input logic [4:0] ra, rb, rc, input bit mid_start,
                          input logic exp_err, input int exp_nreads, input bit chk_res,
                          input int exp_ar_high);
        int w0, r0, d0, b0, o0, h0;
        logic [1:0] prev_res;
        logic [3:0] prev_data;
        w0 = wr_log.size(); r0 = rd_addr_log.size(); d0 = done_cnt;
        b0 = b_accepts; o0 = aw_only_cnt; h0 = ar_high_cnt;
        prev_res = result; prev_data = data;
        @(negedge clk); a = ra; b = rb; c = rc; start = 1;
        @(negedge clk); start = 0;
        check("busy_after_start", {62'd0, busy, err}, 64'h2);
        if (mid_start) begin
            repeat (2) @(negedge clk);
            start = 1; a = ~ra;
            @(negedge clk); start = 0;
        end
        for (int k = 0; k < 300 && done !== 1'b1; k++) @(negedge clk);
        check("done_seen", {63'd0, done}, 64'd1);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("error_at_done", {63'd0, err}, {63'd0, exp_err});
        check("valids_low_at_done", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("write_count", 64'(wr_log.size() - w0), 64'd4);
        if (wr_log.size() - w0 == 4) begin
            check("wr0", wr_log[w0],   {BASE + 32'h0, exp_coef(ra), 4'hF});
            check("wr1", wr_log[w0+1], {BASE + 32'h4, exp_coef(rb), 4'hF});
            check("wr2", wr_log[w0+2], {BASE + 32'h8, exp_coef(rc), 4'hF});
            check("wr3", wr_log[w0+3], {BASE + 32'hC, 32'h1, 4'hF});
        end
        check("b_accepts", 64'(b_accepts - b0), 64'd4);
        check("read_count", 64'(rd_addr_log.size() - r0), 64'(exp_nreads));
        if (exp_ar_high >= 0)
            check("arvalid_cycles", 64'(ar_high_cnt - h0), 64'(exp_ar_high));
        if (rd_addr_log.size() - r0 == 2 && exp_nreads == 2) begin
            check("rd0_addr", {32'd0, rd_addr_log[r0]},   {32'd0, BASE + 32'h10});
            check("rd1_addr", {32'd0, rd_addr_log[r0+1]}, {32'd0, BASE + 32'h14});
            check("o_data", {60'd0, data}, {60'd0, rd_data_log[r0+1][3:0]});
            if (chk_res) check("o_result", {62'd0, result}, {62'd0, rd_data_log[r0][1:0]});
        end
        if (exp_nreads == 0) begin
            check("o_data_held", {60'd0, data}, {60'd0, prev_data});
            check("o_result_held", {62'd0, result}, {62'd0, prev_res});
        end
        if (cfg_aw_delay > cfg_w_delay)
            check("aw_holds_after_w", 64'(aw_only_cnt - o0 > 0), 64'd1);
    endtask

    initial begin
        rst = 1; start = 0; a = '0; b = '0; c = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {48'd0, busy, done, err, result, data, awvalid, wvalid,
                             bready, arvalid, rready, wstrb}, 64'd0);
        check("reset_addr", {awaddr, araddr}, 64'd0);
        check("reset_wdata", {32'd0, wdata}, 64'd0);
        rst = 0;

        // Nominal: a=1, b=-2, c=1, zero-wait slave (ARVALID high one cycle per read)
        do_run(5'd1, 5'h1E, 5'd1, 1'b0, 1'b0, 2, 1'b1, 2);

        // Back-pressure: AWREADY 3 cycles late, WREADY 1 cycle late
        cfg_aw_delay = 3; cfg_w_delay = 1;
        do_run(5'h0F, 5'h10, 5'h13, 1'b0, 1'b0, 2, 1'b1, 2);
        cfg_aw_delay = 0; cfg_w_delay = 0;

        // Error response on RESULT, DATA_OUT still read
        cfg_rresp_result = 2'b10;
        do_run(5'h05, 5'h1B, 5'h00, 1'b0, 1'b1, 2, 1'b0, 2);
        cfg_rresp_result = 2'b00;

        // Next start clears the sticky error
        do_run(5'h02, 5'h03, 5'h04, 1'b0, 1'b0, 2, 1'b1, 2);

        // Timeout: ARREADY never comes, abort after 16 cycles, outputs held
        cfg_ar_never = 1'b1;
        do_run(5'h07, 5'h08, 5'h09, 1'b0, 1'b1, 0, 1'b0, 16);
        cfg_ar_never = 1'b0;

        // Start while busy is ignored
        do_run(5'h11, 5'h0A, 5'h1F, 1'b1, 1'b0, 2, 1'b1, 2);

        // Random coefficients and write back-pressure
        for (int i = 0; i < 5; i++) begin
            cfg_aw_delay = int'($urandom_range(0, 3));
            cfg_w_delay  = int'($urandom_range(0, 3));
            do_run(5'($urandom), 5'($urandom), 5'($urandom), 1'b0, 1'b0, 2, 1'b1, 2);
        end
        cfg_aw_delay = 0; cfg_w_delay = 0;

        check("aw_w_rise_together", 64'(rise_mismatch), 64'd0);

        // Reset mid-write: outputs drop on the next edge, no done pulse
        begin
            int d0;
            d0 = done_cnt;
            cfg_aw_delay = 10; cfg_w_delay = 10;
            @(negedge clk); a = 5'd3; start = 1;
            @(negedge clk); start = 0;
            @(negedge clk);
            check("in_write_before_rst", {62'd0, awvalid, wvalid}, 64'd3);
            rst = 1;
            @(negedge clk);
            check("rst_drops_outputs", {58'd0, busy, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
            repeat (2) @(negedge clk);
            rst = 0;
            repeat (3) @(negedge clk);
            check("idle_after_rst", {58'd0, busy, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
            check("no_done_on_rst", 64'(done_cnt - d0), 64'd0);
            cfg_aw_delay = 0; cfg_w_delay = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
